// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one byte at a time to a UART PISO, with parity generation and a send/done watchdog.
// Grant to piso_send takes 2 cycles; req_ready pulses only on grant, and requesters hold req_valid until they see it.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   baud_clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [1:0]             parity_type,
  output logic                   piso_send,
  output logic [7:0]             piso_data,
  output logic [1:0]             piso_parity_type,
  output logic                   piso_parity_bit,
  input  logic                   piso_active,
  input  logic                   piso_done,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_last_grant;
  logic [WDW-1:0]   r_wdog;

  logic [7:0]       w_valid_pad;
  logic [63:0]      w_data_pad;
  logic [3:0]       w_cand;
  logic             w_gnt_vld;
  logic [2:0]       w_gnt_idx;
  logic [7:0]       w_gnt_byte;
  logic             w_gnt_par;
  logic [7:0]       w_rdy_pad;
  logic             w_expire;

  // Pad to 8 requesters so the index arithmetic never goes out of range.
  always_comb begin
    w_valid_pad = '0;
    w_valid_pad[NUM_REQ-1:0] = req_valid;
    w_data_pad = '0;
    w_data_pad[8*NUM_REQ-1:0] = req_data;
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_last_grant} + 4'd1 + 4'(i);
      if (w_cand >= 4'(NUM_REQ)) w_cand = w_cand - 4'(NUM_REQ);
      if (!w_gnt_vld && w_valid_pad[w_cand[2:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[2:0];
      end
    end
  end

  assign w_gnt_byte = w_data_pad[{w_gnt_idx, 3'b000} +: 8];

  always_comb begin
    case (parity_type)
      2'b01:   w_gnt_par = ~^w_gnt_byte;
      2'b10:   w_gnt_par = ^w_gnt_byte;
      default: w_gnt_par = 1'b0;
    endcase
  end

  // Accept is combinational so the handshake completes on the grant edge itself.
  always_comb begin
    w_rdy_pad = '0;
    if (r_state == IDLE && w_gnt_vld && !reset) w_rdy_pad[w_gnt_idx] = 1'b1;
    req_ready = w_rdy_pad[NUM_REQ-1:0];
  end

  assign w_expire = (r_wdog == WDW'(TIMEOUT - 1));
  assign busy     = (r_state != IDLE);

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_last_grant     <= 3'(NUM_REQ - 1);
      r_wdog           <= '0;
      piso_send        <= 1'b0;
      piso_data        <= '0;
      piso_parity_type <= '0;
      piso_parity_bit  <= 1'b0;
      grant_id         <= '0;
      frame_done       <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            piso_data        <= w_gnt_byte;
            piso_parity_type <= parity_type;
            piso_parity_bit  <= w_gnt_par;
            grant_id         <= w_gnt_idx;
            r_state          <= LOAD;
          end
        end
        LOAD: begin
          r_wdog    <= '0;
          piso_send <= 1'b1;
          r_state   <= SEND;
        end
        SEND, WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          // A done arriving on the expiry cycle still counts as a good frame.
          if (piso_done) begin
            piso_send  <= 1'b0;
            frame_done <= 1'b1;
            r_state    <= DONE;
          end else if (w_expire) begin
            piso_send    <= 1'b0;
            err_timeout  <= 1'b1;
            r_last_grant <= grant_id;
            r_state      <= IDLE;
          end else if (r_state == SEND && piso_active) begin
            piso_send <= 1'b0;
            r_state   <= WAIT;
          end
        end
        DONE: begin
          r_last_grant <= grant_id;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 16, baud_clk cycles allowed from send assertion to piso_done.
REQ-003 SHALL have port baud_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte-pending flag.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-008 SHALL have port parity_type  input  2  00 none, 01 odd, 10 even, 11 none.
REQ-009 SHALL have port piso_send  output  1  frame start request to the PISO.
REQ-010 SHALL have port piso_data  output  8  byte presented to the PISO.
REQ-011 SHALL have port piso_parity_type  output  2  latched parity_type for the current frame.
REQ-012 SHALL have port piso_parity_bit  output  1  computed parity bit.
REQ-013 SHALL have port piso_active  input  1  PISO shifting flag.
REQ-014 SHALL have port piso_done  input  1  PISO frame-complete flag.
REQ-015 SHALL have port grant_id  output  3  index of the current or last granted requester.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse on successful frame completion.
REQ-018 SHALL have port err_timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-019 SHALL implement a state machine with states IDLE, LOAD, SEND, WAIT and DONE.
REQ-020 IDLE SHALL grant, when any req_valid is high, the first requester with req_valid high, searching round-robin from last_grant+1 modulo NUM_REQ.
REQ-021 On grant, the block SHALL in the same cycle pulse req_ready[g], capture req_data[g] into piso_data, latch parity_type, set grant_id=g, and move to LOAD.
REQ-022 LOAD SHALL last exactly one cycle with piso_send=0, giving data setup time, then move to SEND.
REQ-023 SEND SHALL hold piso_send=1 until piso_active=1 is sampled, then move to WAIT with piso_send=0 from the next cycle.
REQ-024 WAIT SHALL move to DONE when piso_done=1 is sampled.
REQ-025 DONE SHALL pulse frame_done for one cycle, set last_grant=g, and return to IDLE; the earliest next grant is the following cycle.
REQ-026 Parity SHALL be computed from the captured byte: odd -> ~^data, even -> ^data, none (00 or 11) -> 0.
REQ-027 The watchdog counter SHALL clear on LOAD->SEND and increment each cycle in SEND and WAIT.
REQ-028 When the watchdog count reaches TIMEOUT-1 without piso_done, the block SHALL pulse err_timeout, drop piso_send, set last_grant=g, and go to IDLE with no frame_done.
REQ-029 If piso_done and watchdog expiry coincide in the same cycle, piso_done SHALL win: DONE is entered and no err_timeout is pulsed.
REQ-030 If piso_done=1 is sampled in SEND, the block SHALL go directly to DONE.
REQ-031 Changes to req_valid, req_data or parity_type after grant SHALL NOT affect the frame in progress.
REQ-032 req_ready SHALL never be asserted outside IDLE, never to more than one requester, and never to a requester whose req_valid is low.
REQ-033 piso_data, piso_parity_type and piso_parity_bit SHALL hold their values from grant until the next grant.

Reset
REQ-034 When reset is sampled high, the block SHALL within one cycle enter IDLE and drive piso_send, req_ready, busy, frame_done, err_timeout, piso_data, piso_parity_type, piso_parity_bit, grant_id and the watchdog to 0.
REQ-035 Reset SHALL set last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-036 Reset asserted mid-frame SHALL abort the frame: piso_send low next cycle, no frame_done, no err_timeout.

Verification
REQ-037 Single request: req_valid=0001, req_data[7:0]=8'h4A, parity_type=01 -> req_ready=0001 for one cycle; LOAD; piso_send=1; piso_data=4A; piso_parity_bit=0 (4A has three ones); frame_done once after piso_done.
REQ-038 Even parity: byte 8'h5A with parity_type=10 -> piso_parity_bit=0; byte 8'h4A with parity_type=10 -> piso_parity_bit=1.
REQ-039 Round-robin: req_valid=1111 held after reset -> grant order 0,1,2,3,0; no requester granted twice before all others are served.
REQ-040 Timeout: grant requester 2, PISO model never asserts piso_done -> err_timeout pulses exactly TIMEOUT cycles after SEND entry; next grant is requester 3.
REQ-041 Coincidence and no-parity: piso_done on the expiry cycle -> frame_done=1, err_timeout=0; parity_type=11 -> piso_parity_bit=0.
REQ-042 Reset in WAIT -> next cycle busy=0, piso_send=0, grant_id=0; with req_valid=0110, the next grant is requester 1.
